itcm_loader: RTL and testbench

ITCM_LOADER -- requirements
Module: itcm_loader

---
 rtl/itcm_loader.sv | 159 +++++++++++++++
 tb/tb_itcm_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_loader.sv
// Byte-stream loader that packs incoming bytes little-endian into ITCM words and writes them
// to a bounds-checked address range. Optional ITCM_LOADER_CHECKSUM_EN adds a running word sum.
module itcm_loader #(
    parameter int DW = 32,
    parameter int AW = 14
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len_words,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] itcm_addr,
    output logic [DW-1:0] itcm_wdata,
    output logic          itcm_wen,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   checksum
);

    localparam int NB = DW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0]   LAST_IDX = BW'(NB - 1);
    localparam logic [AW+1:0]   DP       = {2'b01, {AW{1'b0}}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] FIN     = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [AW-1:0]      base_reg;
    logic [AW:0]        len_reg;
    logic [AW:0]        word_cnt_reg;
    logic [BW-1:0]      byte_idx_reg;
    logic               err_reg;
    logic [NB-1:0][7:0] word_reg;
    logic [NB-1:0]      lane_we;

    logic               accept;
    logic               last_byte;
    logic [AW+1:0]      end_sum;
    logic               range_bad;
    logic [AW:0]        word_cnt_inc;

    assign accept       = (state_reg == COLLECT) && byte_valid;
    assign last_byte    = accept && (byte_idx_reg == LAST_IDX);
    // Range check is done one bit wider than the sum can reach, so it can never wrap.
    assign end_sum      = {2'b00, base_addr} + {1'b0, len_words};
    assign range_bad    = end_sum > DP;
    assign word_cnt_inc = word_cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (range_bad || (len_words == '0))
                        state_next = FIN;
                    else
                        state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (last_byte)
                    state_next = WRITE;
            end
            WRITE: begin
                if (word_cnt_inc == len_reg)
                    state_next = FIN;
                else
                    state_next = COLLECT;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                base_reg     <= base_addr;
                len_reg      <= len_words;
                word_cnt_reg <= '0;
                byte_idx_reg <= '0;
                err_reg      <= range_bad;
            end else begin
                if (accept)
                    byte_idx_reg <= last_byte ? '0 : byte_idx_reg + 1'b1;
                if (state_reg == WRITE)
                    word_cnt_reg <= word_cnt_inc;
            end
        end
    end

    // One write enable per byte lane, selected by the running byte index.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = accept && (byte_idx_reg == BW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            word_reg <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lane_we[i])
                    word_reg[i] <= byte_in;
            end
        end
    end

    assign byte_ready = (state_reg == COLLECT);
    assign itcm_wen   = (state_reg == WRITE);
    assign itcm_wdata = itcm_wen ? word_reg : '0;
    // Address cannot wrap: the start-time range check bounds base + count below DP.
    assign itcm_addr  = itcm_wen ? (base_reg + word_cnt_reg[AW-1:0]) : '0;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign err        = done && err_reg;

`ifdef ITCM_LOADER_CHECKSUM_EN
    localparam int CW = (DW < 32) ? DW : 32;

    logic [31:0] checksum_reg;
    logic [31:0] word_low;
    logic [DW-1:0] word_flat;

    assign word_flat = word_reg;
    assign word_low  = 32'(word_flat[CW-1:0]);

    always_ff @(posedge CLK) begin
        if (RST)
            checksum_reg <= '0;
        else if (state_reg == IDLE && start)
            checksum_reg <= '0;
        else if (state_reg == WRITE)
            checksum_reg <= checksum_reg + word_low;
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_itcm_loader.sv
// Directed bench for itcm_loader: back-to-back load, throttled bytes, range error, empty load,
// mid-load reset and start-while-busy, with writes captured by a monitor.
module tb_itcm_loader;
    localparam int DW = 32;
    localparam int AW = 14;

`ifdef ITCM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len_words;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] itcm_addr;
    logic [DW-1:0] itcm_wdata;
    logic          itcm_wen;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    itcm_loader #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .len_words(len_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata), .itcm_wen(itcm_wen),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor samples 2 time units after each rising edge.
    int            wr_n = 0, done_n = 0, ready_n = 0;
    logic [AW-1:0] wr_addr [64];
    logic [DW-1:0] wr_data [64];
    int            wr_cyc  [64];
    int            done_cyc = -1;
    logic          done_err = 1'b0;

    always @(posedge CLK) begin
        #2;
        if (itcm_wen && wr_n < 64) begin
            wr_addr[wr_n] = itcm_addr;
            wr_data[wr_n] = itcm_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            done_err = err;
        end
        if (byte_ready) ready_n++;
    end

    int errors = 0;
    int checks = 0;
    int st_cyc, acc_cyc, acc1, acc2, k;
    int w0, d0, r0;
    logic [7:0] t2b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start     = 1'b1;
        base_addr = b;
        len_words = l;
        st_cyc    = cyc;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready) begin
                acc_cyc = cyc;
                @(negedge CLK);
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL push_timeout: observed=no byte_ready expected=byte 0x%0h accepted", b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 1'b0; base_addr = '0; len_words = '0;
        byte_in = '0; byte_valid = 1'b0;
        idle(3);
        check("rst_busy",     64'(busy),       64'd0);
        check("rst_done",     64'(done),       64'd0);
        check("rst_err",      64'(err),        64'd0);
        check("rst_ready",    64'(byte_ready), 64'd0);
        check("rst_wen",      64'(itcm_wen),   64'd0);
        check("rst_wdata",    64'(itcm_wdata), 64'd0);
        check("rst_addr",     64'(itcm_addr),  64'd0);
        check("rst_checksum", 64'(checksum),   64'd0);
        RST = 1'b0;
        idle(1);

        // Back-to-back two-word load
        w0 = wr_n; d0 = done_n;
        do_start(14'h10, 15'd2);
        check("t1_busy", 64'(busy), 64'd1);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); acc1 = acc_cyc;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88); acc2 = acc_cyc;
        byte_valid = 1'b0;
        idle(4);
        check("t1_wr_count", 64'(wr_n - w0),        64'd2);
        check("t1_addr0",    64'(wr_addr[w0]),      64'h10);
        check("t1_data0",    64'(wr_data[w0]),      64'h44332211);
        check("t1_addr1",    64'(wr_addr[w0+1]),    64'h11);
        check("t1_data1",    64'(wr_data[w0+1]),    64'h88776655);
        check("t1_wr0_lat",  64'(wr_cyc[w0]),       64'(acc1 + 1));
        check("t1_wr1_lat",  64'(wr_cyc[w0+1]),     64'(acc2 + 1));
        check("t1_done_cnt", 64'(done_n - d0),      64'd1);
        check("t1_done_cyc", 64'(done_cyc),        64'(wr_cyc[w0+1] + 1));
        check("t1_err",      64'(done_err),         64'd0);
        check("t1_checksum", 64'(checksum),         CK_EN ? 64'hCCAA8866 : 64'd0);
        check("t1_idle",     64'(busy),             64'd0);

        // Throttled bytes, valid toggling every cycle
        w0 = wr_n; d0 = done_n;
        do_start(14'h20, 15'd1);
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            byte_valid = (i % 2 == 0);
            byte_in    = t2b[k];
            if (byte_valid && byte_ready) begin
                acc_cyc = cyc;
                k++;
            end
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        idle(4);
        check("t2_bytes",    64'(k),             64'd4);
        check("t2_wr_count", 64'(wr_n - w0),     64'd1);
        check("t2_addr",     64'(wr_addr[w0]),   64'h20);
        check("t2_data",     64'(wr_data[w0]),   64'h04030201);
        check("t2_wr_lat",   64'(wr_cyc[w0]),    64'(acc_cyc + 1));
        check("t2_done_cnt", 64'(done_n - d0),   64'd1);

        // Range error at top of memory
        w0 = wr_n; d0 = done_n; r0 = ready_n;
        do_start(14'h3FFF, 15'd2);
        idle(3);
        check("t3_wr_count", 64'(wr_n - w0),     64'd0);
        check("t3_done_cnt", 64'(done_n - d0),   64'd1);
        check("t3_done_cyc", 64'(done_cyc),      64'(st_cyc + 1));
        check("t3_err",      64'(done_err),      64'd1);
        check("t3_ready",    64'(ready_n - r0),  64'd0);
        check("t3_err_low",  64'(err),           64'd0);

        // Last legal word of memory
        w0 = wr_n; d0 = done_n;
        do_start(14'h3FFF, 15'd1);
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        byte_valid = 1'b0;
        idle(4);
        check("t3b_wr_count", 64'(wr_n - w0),    64'd1);
        check("t3b_addr",     64'(wr_addr[w0]),  64'h3FFF);
        check("t3b_data",     64'(wr_data[w0]),  64'hD4C3B2A1);
        check("t3b_err",      64'(done_err),     64'd0);

        // Empty load
        w0 = wr_n; d0 = done_n; r0 = ready_n;
        do_start(14'h100, 15'd0);
        idle(3);
        check("t4_wr_count", 64'(wr_n - w0),     64'd0);
        check("t4_done_cnt", 64'(done_n - d0),   64'd1);
        check("t4_done_cyc", 64'(done_cyc),      64'(st_cyc + 1));
        check("t4_err",      64'(done_err),      64'd0);
        check("t4_ready",    64'(ready_n - r0),  64'd0);

        // Reset in the middle of a word, then a fresh load
        w0 = wr_n; d0 = done_n;
        do_start(14'h30, 15'd1);
        push(8'h12); push(8'h34);
        byte_valid = 1'b0;
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(3);
        check("t5_wr_count", 64'(wr_n - w0),     64'd0);
        check("t5_done_cnt", 64'(done_n - d0),   64'd0);
        check("t5_busy",     64'(busy),          64'd0);
        check("t5_checksum", 64'(checksum),      64'd0);
        w0 = wr_n; d0 = done_n;
        do_start(14'h40, 15'd1);
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        byte_valid = 1'b0;
        idle(4);
        check("t5b_wr_count", 64'(wr_n - w0),    64'd1);
        check("t5b_addr",     64'(wr_addr[w0]),  64'h40);
        check("t5b_data",     64'(wr_data[w0]),  64'hDDCCBBAA);
        check("t5b_done_cnt", 64'(done_n - d0),  64'd1);
        check("t5b_checksum", 64'(checksum),     CK_EN ? 64'hDDCCBBAA : 64'd0);

        // Start pulsed while busy is ignored
        w0 = wr_n; d0 = done_n;
        do_start(14'h50, 15'd2);
        push(8'h01); push(8'h02);
        byte_valid = 1'b0;
        start = 1'b1; base_addr = 14'h0; len_words = 15'd1;
        @(negedge CLK);
        start = 1'b0;
        push(8'h03); push(8'h04); push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        byte_valid = 1'b0;
        idle(4);
        check("t6_wr_count", 64'(wr_n - w0),     64'd2);
        check("t6_addr0",    64'(wr_addr[w0]),   64'h50);
        check("t6_data0",    64'(wr_data[w0]),   64'h04030201);
        check("t6_addr1",    64'(wr_addr[w0+1]), 64'h51);
        check("t6_data1",    64'(wr_data[w0+1]), 64'h08070605);
        check("t6_done_cnt", 64'(done_n - d0),   64'd1);
        check("t6_err",      64'(done_err),      64'd0);
        check("t6_checksum", 64'(checksum),      CK_EN ? 64'h0C0A0806 : 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
